// File: rtl/aes_in_queue.sv
// aes_in_queue: multi-channel packet FIFO with round-robin, key-locking arbitration into the AES engine
module aes_in_queue #(
  parameter int WIDTH = 131,
  parameter int DEPTH = 32,
  parameter int NUM_CH = 2,
  parameter int AF_LEVEL = DEPTH - 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]       flush,
  input  logic                    load_data,
  output logic [WIDTH-1:0]        dout,
  output logic [CHW-1:0]          dout_ch,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH*CW-1:0]    count,
  output logic [NUM_CH-1:0]       ovf_err
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] heads [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [CHW-1:0] gnt, rr_ptr, lock_ch, nxt;
  logic lock_on, any, grant;
  assign grant = load_data && any;
  assign nxt = int'(gnt) == NUM_CH - 1 ? '0 : gnt + CHW'(1);
  // Pick a channel: round-robin from rr_ptr, overridden by a live key lock
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_CH]) begin
        any = 1'b1;
        gnt = CHW'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
    if (lock_on && elig[lock_ch]) begin
      any = 1'b1;
      gnt = lock_ch;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic ovf, acc, rd;
    assign acc = wr_en[c] && !full[c] && !flush[c];
    assign rd = grant && gnt == CHW'(c);
    assign elig[c] = cnt != '0 && !flush[c];
    assign heads[c] = mem[rp];
    assign full[c] = cnt == CW'(DEPTH);
    assign almost_full[c] = cnt >= CW'(AF_LEVEL);
    assign empty[c] = cnt == '0;
    assign count[c*CW +: CW] = cnt;
    assign ovf_err[c] = ovf;
    // Storage is never cleared; pointers alone define which entries are live
    always_ff @(posedge clk) if (acc) mem[wp] <= din[c*WIDTH +: WIDTH];
    // Pointers, occupancy and sticky overflow; flush wins over write and read
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (wr_en[c] && full[c]) ovf <= 1'b1;
        if (flush[c]) begin
          wp <= '0;
          rp <= '0;
          cnt <= '0;
        end else begin
          if (acc) wp <= wp + AW'(1);
          if (rd) rp <= rp + AW'(1);
          cnt <= cnt + CW'(acc) - CW'(rd);
        end
      end
    end
  end
  // Register the granted head, advance round-robin and track the key lock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout <= '0;
      dout_ch <= '0;
      rr_ptr <= '0;
      lock_on <= 1'b0;
      lock_ch <= '0;
    end else if (grant) begin
      dout <= heads[gnt] | WIDTH'(1);
      dout_ch <= gnt;
      rr_ptr <= nxt;
      lock_on <= heads[gnt][1];
      lock_ch <= gnt;
    end else begin
      dout[0] <= 1'b0;
      if (lock_on && !elig[lock_ch]) lock_on <= 1'b0;
    end
  end
endmodule

// File: doc/aes_in_queue.md
AES_IN_QUEUE -- requirements
Module: aes_in_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 131, meaning the packet width: data[127:0], en_de, set_key, valid.
REQ-002 SHALL have parameter DEPTH, default 32, meaning the entries per channel; legal values are powers of two, minimum 2.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning the number of independent input channels; legal range is 1..8.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4, meaning the occupancy at or above which almost_full asserts.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, NUM_CH bits: per-channel write strobe.
REQ-008 SHALL have port din, input, NUM_CH x WIDTH bits: per-channel write packet.
REQ-009 SHALL have port flush, input, NUM_CH bits: per-channel synchronous clear.
REQ-010 SHALL have port load_data, input, 1 bit: engine ready to accept one packet.
REQ-011 SHALL have port dout, output, WIDTH bits: packet delivered to the engine.
REQ-012 SHALL have port dout_ch, output, $clog2(NUM_CH) bits (minimum 1): source channel of dout.
REQ-013 SHALL have port full, output, NUM_CH bits: count equals DEPTH.
REQ-014 SHALL have port almost_full, output, NUM_CH bits: count >= AF_LEVEL.
REQ-015 SHALL have port empty, output, NUM_CH bits: count equals 0.
REQ-016 SHALL have port count, output, NUM_CH x $clog2(DEPTH+1) bits: per-channel occupancy.
REQ-017 SHALL have port ovf_err, output, NUM_CH bits: sticky flag, set on a write to a full channel.

Function
REQ-018 Each channel SHALL be a circular FIFO with read/write pointers that wrap modulo DEPTH.
REQ-019 A write SHALL be accepted when wr_en[i]=1 and full[i]=0, as sampled before the edge; a same-cycle read does not unblock a full channel.
REQ-020 A write to a full channel SHALL be dropped, leave storage and count unchanged, and set ovf_err[i] until reset.
REQ-021 Channel i SHALL be eligible when count[i]>0 before the edge; a packet written in the same cycle is not readable until the next cycle.
REQ-022 When load_data=1 and at least one channel is eligible, the block SHALL grant exactly one channel by round-robin, starting from the channel after the last granted; after reset, the search starts at channel 0.
REQ-023 On a grant, the head entry SHALL be registered into dout with dout.valid forced to 1, dout_ch set to the granted channel, and that channel's read pointer advanced; latency from load_data to dout is 1 cycle.
REQ-024 In a cycle where no grant occurs, the next cycle SHALL have dout.valid=0 with the other dout bits holding their previous values.
REQ-025 Simultaneous accepted write and grant on one channel SHALL leave its count unchanged.
REQ-026 A key packet with set_key=1 SHALL lock arbitration to its channel, continuing only while that channel is eligible.
REQ-027 The lock SHALL release after the next granted packet from that channel, or when that channel empties or is flushed.
REQ-028 flush[i]=1 SHALL zero pointers and count of channel i at the edge, override a same-cycle write and grant on that channel, and leave ovf_err unchanged.
REQ-029 The count, full, almost_full and empty outputs SHALL be registered or derived only from registered state, and SHALL update at the same edge that changes occupancy.

Reset
REQ-030 On rstn=0, asynchronously: all pointers and counts SHALL be 0, empty all-ones, full, almost_full and ovf_err all-zero, dout all-zero (valid=0), dout_ch=0, round-robin pointer 0, key lock cleared.
REQ-031 Reset mid-operation SHALL discard all stored packets; storage RAM contents need not be cleared.

Verification
REQ-032 Single channel, write 3 packets (data 0x1,0x2,0x3), then load_data=1 for 3 cycles -> dout.data 0x1,0x2,0x3 on the following cycles, valid=1, dout_ch=0, then empty[0]=1.
REQ-033 Channels 0 and 1 each hold 2 packets, load_data held high -> dout_ch sequence 0,1,0,1.
REQ-034 Write DEPTH+1 packets to channel 1 -> full[1]=1, count=DEPTH, ovf_err[1]=1, extra packet never appears on dout; almost_full[1] rises when count reaches AF_LEVEL.
REQ-035 Channel 0 holds key packet (set_key=1) then data A; channel 1 holds data B; rr pointer at 0 -> dout order key, A, B.
REQ-036 Full channel with simultaneous write and grant -> write dropped, count DEPTH-1; empty channel with simultaneous write and load_data -> no grant, dout.valid=0, count 1.
REQ-037 Assert rstn=0 mid-stream with 5 queued packets -> outputs take reset values immediately; after release, load_data yields dout.valid=0.
